// File: rtl/logic_axi4_lite_pkg.sv
// logic_axi4_lite_pkg: shared types for the AXI4-Lite slave route stage
//   tok_state_t  - state of an AW/AR route token register
//   route_width  - bit width of a packed {hit, id} route entry
package logic_axi4_lite_pkg;
  typedef enum logic {TOK_IDLE, TOK_VALID} tok_state_t;
  function automatic int route_width(input int slaves_width);
    return slaves_width + 1;
  endfunction
endpackage

// File: rtl/logic_axi4_lite_bus_route_fifo.sv
// logic_axi4_lite_bus_route_fifo: register-based in-order FIFO of route entries
//   clk_i/rst_i      clock, asynchronous active-high reset
//   push_i/data_i    write side
//   pop_i/data_o     read side, data_o is the head entry
//   full_o/empty_o   occupancy flags
module logic_axi4_lite_bus_route_fifo #(
  parameter int WIDTH    = 1,
  parameter int CAPACITY = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int PW = CAPACITY > 1 ? $clog2(CAPACITY) : 1;
  localparam int CW = $clog2(CAPACITY + 1);
  logic [WIDTH-1:0] mem_q [CAPACITY];
  logic [PW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return p == PW'(CAPACITY - 1) ? '0 : p + 1'b1;
  endfunction
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < CAPACITY; i++) mem_q[i] <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_q] <= data_i;
        wr_q        <= nxt(wr_q);
      end
      if (pop_i) rd_q <= nxt(rd_q);
      cnt_q <= cnt_q + CW'(push_i) - CW'(pop_i);
    end
  assign data_o  = mem_q[rd_q];
  assign full_o  = cnt_q == CW'(CAPACITY);
  assign empty_o = cnt_q == '0;
endmodule

// File: rtl/logic_axi4_lite_bus_slave_route.sv
// logic_axi4_lite_bus_slave_route: decodes AW/AR addresses to slave routes and issues in-order route tokens
//   aclk_i/areset_i        clock, asynchronous active-high reset
//   awvalid_i/awaddr_i     upstream write address (monitored only)
//   arvalid_i/araddr_i     upstream read address (monitored only)
//   {aw,w,b,ar,r}_t*       route token streams: tvalid_o/tready_i, tid_o = slave index, tuser_o = hit
module logic_axi4_lite_bus_slave_route
  import logic_axi4_lite_pkg::*;
#(
  parameter int SLAVES         = 1,
  parameter int SLAVES_WIDTH   = (SLAVES >= 2) ? $clog2(SLAVES) : 1,
  parameter int ADDRESS_WIDTH  = 1,
  parameter logic [SLAVES-1:0][ADDRESS_WIDTH-1:0] SLAVES_ADDRESS = '0,
  parameter logic [SLAVES-1:0][ADDRESS_WIDTH-1:0] SLAVES_MASK    = '0,
  parameter int OUTSTANDING    = 4
) (
  input  logic                     aclk_i,
  input  logic                     areset_i,
  input  logic                     awvalid_i,
  input  logic [ADDRESS_WIDTH-1:0] awaddr_i,
  input  logic                     arvalid_i,
  input  logic [ADDRESS_WIDTH-1:0] araddr_i,
  output logic                     aw_tvalid_o,
  input  logic                     aw_tready_i,
  output logic [SLAVES_WIDTH-1:0]  aw_tid_o,
  output logic                     aw_tuser_o,
  output logic                     w_tvalid_o,
  input  logic                     w_tready_i,
  output logic [SLAVES_WIDTH-1:0]  w_tid_o,
  output logic                     w_tuser_o,
  output logic                     b_tvalid_o,
  input  logic                     b_tready_i,
  output logic [SLAVES_WIDTH-1:0]  b_tid_o,
  output logic                     b_tuser_o,
  output logic                     ar_tvalid_o,
  input  logic                     ar_tready_i,
  output logic [SLAVES_WIDTH-1:0]  ar_tid_o,
  output logic                     ar_tuser_o,
  output logic                     r_tvalid_o,
  input  logic                     r_tready_i,
  output logic [SLAVES_WIDTH-1:0]  r_tid_o,
  output logic                     r_tuser_o
);
  typedef struct packed {
    logic                    hit;
    logic [SLAVES_WIDTH-1:0] id;
  } route_t;
  localparam int RW = route_width(SLAVES_WIDTH);
  // scanning downwards lets the lowest matching slave overwrite the others
  function automatic route_t decode(input logic [ADDRESS_WIDTH-1:0] a);
    route_t r;
    r = '0;
    for (int k = SLAVES - 1; k >= 0; k--)
      if ((a & SLAVES_MASK[k]) == SLAVES_ADDRESS[k]) r = '{hit: 1'b1, id: SLAVES_WIDTH'(k)};
    return r;
  endfunction
  tok_state_t aw_st_q, ar_st_q;
  route_t aw_q, ar_q, w_head, b_head, r_head;
  logic w_full, w_empty, b_full, b_empty, r_full, r_empty;
  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
  // after a handshake the token always drops for a cycle: the upstream
  // address is still the accepted one at that edge and must not be reissued
  always_ff @(posedge aclk_i or posedge areset_i)
    if (areset_i) begin
      aw_st_q <= TOK_IDLE;
      aw_q    <= '0;
    end else if (aw_st_q == TOK_VALID) begin
      if (aw_tready_i) aw_st_q <= TOK_IDLE;
    end else if (awvalid_i && !w_full) begin
      aw_st_q <= TOK_VALID;
      aw_q    <= decode(awaddr_i);
    end
  always_ff @(posedge aclk_i or posedge areset_i)
    if (areset_i) begin
      ar_st_q <= TOK_IDLE;
      ar_q    <= '0;
    end else if (ar_st_q == TOK_VALID) begin
      if (ar_tready_i) ar_st_q <= TOK_IDLE;
    end else if (arvalid_i && !r_full) begin
      ar_st_q <= TOK_VALID;
      ar_q    <= decode(araddr_i);
    end
  assign aw_tvalid_o = aw_st_q == TOK_VALID;
  assign ar_tvalid_o = ar_st_q == TOK_VALID;
  // W waits for room in B so every released write keeps its response route
  assign w_tvalid_o  = !w_empty && !b_full;
  assign b_tvalid_o  = !b_empty;
  assign r_tvalid_o  = !r_empty;
  assign aw_hs = aw_tvalid_o && aw_tready_i;
  assign w_hs  = w_tvalid_o && w_tready_i;
  assign b_hs  = b_tvalid_o && b_tready_i;
  assign ar_hs = ar_tvalid_o && ar_tready_i;
  assign r_hs  = r_tvalid_o && r_tready_i;
  assign {aw_tuser_o, aw_tid_o} = aw_q;
  assign {w_tuser_o, w_tid_o}   = w_head;
  assign {b_tuser_o, b_tid_o}   = b_head;
  assign {ar_tuser_o, ar_tid_o} = ar_q;
  assign {r_tuser_o, r_tid_o}   = r_head;
  logic_axi4_lite_bus_route_fifo #(.WIDTH(RW), .CAPACITY(OUTSTANDING)) u_w_fifo (
    .clk_i(aclk_i), .rst_i(areset_i), .push_i(aw_hs), .pop_i(w_hs),
    .data_i(aw_q), .data_o(w_head), .full_o(w_full), .empty_o(w_empty)
  );
  logic_axi4_lite_bus_route_fifo #(.WIDTH(RW), .CAPACITY(OUTSTANDING)) u_b_fifo (
    .clk_i(aclk_i), .rst_i(areset_i), .push_i(w_hs), .pop_i(b_hs),
    .data_i(w_head), .data_o(b_head), .full_o(b_full), .empty_o(b_empty)
  );
  logic_axi4_lite_bus_route_fifo #(.WIDTH(RW), .CAPACITY(OUTSTANDING)) u_r_fifo (
    .clk_i(aclk_i), .rst_i(areset_i), .push_i(ar_hs), .pop_i(r_hs),
    .data_i(ar_q), .data_o(r_head), .full_o(r_full), .empty_o(r_empty)
  );
endmodule
